// File: rtl/data_encryption.sv
// Decoder stage of the encrypted-data reader: emits the sign-magnitude difference
// of the Hamming weights of two code words, two clocks after they are sampled.
module data_encryption #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [4:0]        out,
  output logic              out_valid
);

  // Handshake: no backpressure. in1/in2 are taken on every rising edge where
  // in_valid is high, and out_valid pulses once per taken pair, two edges later.

  function automatic logic [3:0] popcount(input logic [DATA_W-1:0] d);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + {3'b000, d[i]};
    end
    return cnt;
  endfunction

  logic [3:0] w1;
  logic [3:0] w2;
  logic       v1;
  logic [4:0] diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1 <= 4'd0;
      w2 <= 4'd0;
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        w1 <= popcount(in1);
        w2 <= popcount(in2);
      end
    end
  end

  // Equal weights take the non-negative branch, so zero is never signed.
  always_comb begin
    diff = 5'd0;
    if (w1 >= w2) begin
      diff = {1'b0, w1 - w2};
    end else begin
      diff = {1'b1, w2 - w1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 5'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        out <= diff;
      end
    end
  end

endmodule

// File: tb/tb_data_encryption.sv
// Directed and randomised checks of the weight-difference decoder.
module tb_data_encryption;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [9:0] in1;
  logic [9:0] in2;
  logic [4:0] out;
  logic       out_valid;

  int compared;
  int mismatched;
  logic [4:0] exp_q[$];

  data_encryption #(.DATA_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] a, input logic [9:0] b);
    in_valid = v;
    in1      = a;
    in2      = b;
  endtask

  function automatic logic [4:0] model(input logic [9:0] a, input logic [9:0] b);
    int d;
    d = $countones(a) - $countones(b);
    if (d < 0) return {1'b1, 4'(-d)};
    return {1'b0, 4'(d)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    drive(1'b1, 10'h2a5, 10'h013);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (out !== 5'b00000) begin
      mismatched++;
      $display("FAIL reset_out: got %b expected 00000", out);
    end
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    step();
    step();
    rst_n = 1'b1;
    drive(1'b0, 10'h3ff, 10'h000);
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (out_valid !== 1'b0 || out !== 5'b00000) begin
        mismatched++;
        $display("FAIL idle_after_reset: got valid=%b out=%b expected valid=0 out=00000", out_valid, out);
      end
    end
  endtask

  task automatic test_equal_weight();
    drive(1'b1, 10'b0010001100, 10'b0010010100);
    step();
    drive(1'b0, 10'h000, 10'h000);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL equal_latency: got valid=%b expected 0 after one edge", out_valid);
    end
    step();
    compared++;
    if (out_valid !== 1'b1 || out !== 5'b00000) begin
      mismatched++;
      $display("FAIL equal_weight: got valid=%b out=%b expected valid=1 out=00000", out_valid, out);
    end
    step();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL equal_valid_pulse: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_extremes();
    drive(1'b1, 10'b1111111111, 10'b0000000000);
    step();
    drive(1'b1, 10'b0000000000, 10'b1111111111);
    step();
    compared++;
    if (out_valid !== 1'b1 || out !== 5'b01010) begin
      mismatched++;
      $display("FAIL extreme_pos: got valid=%b out=%b expected valid=1 out=01010", out_valid, out);
    end
    drive(1'b0, 10'h000, 10'h000);
    step();
    compared++;
    if (out_valid !== 1'b1 || out !== 5'b11010) begin
      mismatched++;
      $display("FAIL extreme_neg: got valid=%b out=%b expected valid=1 out=11010", out_valid, out);
    end
    step();
    compared++;
    if (out_valid !== 1'b0 || out !== 5'b11010) begin
      mismatched++;
      $display("FAIL extreme_hold: got valid=%b out=%b expected valid=0 out=11010", out_valid, out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 10'b0000000001, 10'b0000000111);
    step();
    drive(1'b1, 10'b1010101010, 10'b0000000000);
    step();
    compared++;
    if (out_valid !== 1'b1 || out !== 5'b10010) begin
      mismatched++;
      $display("FAIL b2b_0: got valid=%b out=%b expected valid=1 out=10010", out_valid, out);
    end
    drive(1'b1, 10'b0000000000, 10'b0000000000);
    step();
    compared++;
    if (out_valid !== 1'b1 || out !== 5'b00101) begin
      mismatched++;
      $display("FAIL b2b_1: got valid=%b out=%b expected valid=1 out=00101", out_valid, out);
    end
    drive(1'b0, 10'h155, 10'h001);
    step();
    compared++;
    if (out_valid !== 1'b1 || out !== 5'b00000) begin
      mismatched++;
      $display("FAIL b2b_2: got valid=%b out=%b expected valid=1 out=00000", out_valid, out);
    end
    step();
    compared++;
    if (out_valid !== 1'b0 || out !== 5'b00000) begin
      mismatched++;
      $display("FAIL b2b_drain: got valid=%b out=%b expected valid=0 out=00000", out_valid, out);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 10'b1111100000, 10'b0000000001);
    step();
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out !== 5'b00000) begin
      mismatched++;
      $display("FAIL mid_reset_async: got valid=%b out=%b expected valid=0 out=00000", out_valid, out);
    end
    drive(1'b1, 10'b1111111111, 10'b0000000000);
    step();
    compared++;
    if (out_valid !== 1'b0 || out !== 5'b00000) begin
      mismatched++;
      $display("FAIL mid_reset_held: got valid=%b out=%b expected valid=0 out=00000", out_valid, out);
    end
    rst_n = 1'b1;
    drive(1'b0, 10'h000, 10'h000);
    step();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_discard: got valid=%b expected 0", out_valid);
    end
    drive(1'b1, 10'b0000000000, 10'b1110000000);
    step();
    drive(1'b0, 10'h000, 10'h000);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_latency: got valid=%b expected 0", out_valid);
    end
    step();
    compared++;
    if (out_valid !== 1'b1 || out !== 5'b10011) begin
      mismatched++;
      $display("FAIL mid_reset_result: got valid=%b out=%b expected valid=1 out=10011", out_valid, out);
    end
    step();
  endtask

  task automatic test_random_stream();
    logic [9:0] a;
    logic [9:0] b;
    logic [4:0] e;
    for (int i = 0; i <= 24; i++) begin
      if (i < 24) begin
        a = 10'($urandom_range(0, 1023));
        b = 10'($urandom_range(0, 1023));
        drive(1'b1, a, b);
        exp_q.push_back(model(a, b));
      end else begin
        drive(1'b0, 10'h000, 10'h000);
      end
      step();
      if (i >= 1) begin
        e = exp_q.pop_front();
        compared++;
        if (out_valid !== 1'b1 || out !== e) begin
          mismatched++;
          $display("FAIL random_%0d: got valid=%b out=%b expected valid=1 out=%b", i - 1, out_valid, out, e);
        end
      end
    end
    step();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL random_drain: got valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    drive(1'b0, 10'h000, 10'h000);
    test_reset();
    test_equal_weight();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_encryption.md
Name: data_encryption

Overview:
- Decoder stage of the encrypted-data reader.
- Each input word is a 10-bit code whose information content is its count of set bits (Hamming weight).
- The block compares the two codes and emits the signed weight difference, weight(in1) − weight(in2), as 1 sign bit plus 4 magnitude bits.
- Sits between the input capture registers and the display/readout logic; pipelined, one result per clock.

Parameters:
- DATA_W, 10, width of in1/in2. Output width is fixed at 5 for the default; other values are not required to be supported.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in1/in2 are sampled this cycle when high
- in1  input  10  first encrypted code word
- in2  input  10  second encrypted code word
- out  output  5  {sign, magnitude[3:0]} of weight(in1) − weight(in2)
- out_valid  output  1  high for one cycle per accepted input, aligned with new out

Behaviour:
- Reset: while rst_n = 0, all pipeline registers, out and out_valid are 0, asynchronously. Internal weight registers are also cleared.
- Stage 1, on a clock edge with in_valid = 1:
  - w1 <= popcount(in1), 4 bits, range 0..10.
  - w2 <= popcount(in2), 4 bits, range 0..10.
  - v1 <= 1.
  - If in_valid = 0, then v1 <= 0; w1/w2 may hold.
- Stage 2, on every clock edge:
  - If v1 = 1:
    - w1 ≥ w2 → out <= {1'b0, w1 − w2}.
    - w1 < w2 → out <= {1'b1, w2 − w1}.
  - If v1 = 0, out holds its previous value.
  - out_valid <= v1.
- Latency: exactly 2 clocks from the sampling edge to the edge where out/out_valid update. Throughput: 1 result per clock; back-to-back in_valid fully supported, no stalls, no backpressure.
- Zero result: always encoded 5'b00000. Negative zero is never produced.
- Magnitude range 0..10 fits in 4 bits without saturation. Sign-magnitude encoding, not two's complement.
- in1 == in2, or any two words of equal weight → 00000.
- Reset asserted mid-stream: in-flight results are discarded. out and out_valid read 0 immediately. The first valid output after release comes 2 cycles after the first accepted input.
- Purely synchronous datapath apart from reset. No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_n = 0 with arbitrary inputs → out = 00000 and out_valid = 0 immediately. Both stay 0 until 2 clocks after the first in_valid following release.
- in1 = 0010001100, in2 = 0010010100 (weights 3, 3), in_valid pulse → out = 0_0000 and out_valid = 1 two clocks later.
- in1 = 1111111111, in2 = 0000000000 → out = 0_1010. Swapped operands → out = 1_1010.
- Back-to-back stream, one pair per clock:
  - (0000000001, 0000000111) → 1_0010
  - (1010101010, 0000000000) → 0_0101
  - (0000000000, 0000000000) → 0_0000
  - Expect each result on consecutive cycles with out_valid held high; after in_valid drops, out holds 0_0000 and out_valid falls.
- Reset mid-operation: accept 2 pairs, assert rst_n = 0 between them → no out_valid for the discarded pairs. A new pair after release produces the correct result 2 clocks later.
